// File: rtl/ipml_fifo_ctrl_v1_5_sync_mc.sv
// Single-clock multi-channel FIFO controller: one shared SDP RAM split into c_CH_NUM regions.
// Optional FIFO_CTRL_PEAK_LEVEL_EN adds a per-channel peak water-level output.

module ipml_fifo_ctrl_v1_5_sync_mc_ch #(
    parameter int c_DEPTH_WIDTH      = 9,
    parameter int c_ALMOST_FULL_NUM  = 508,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wreq,
    input  logic                     i_rreq,
    input  logic                     i_flush,
    output logic                     o_wacc,
    output logic                     o_racc,
    output logic [c_DEPTH_WIDTH-1:0] o_wptr,
    output logic [c_DEPTH_WIDTH-1:0] o_rptr,
    output logic                     o_full,
    output logic                     o_afull,
    output logic                     o_empty,
    output logic                     o_aempty,
    output logic [c_DEPTH_WIDTH:0]   o_level,
`ifdef FIFO_CTRL_PEAK_LEVEL_EN
    output logic [c_DEPTH_WIDTH:0]   o_peak,
`endif
    output logic                     o_ovf,
    output logic                     o_udf
);
    localparam int W = c_DEPTH_WIDTH + 1;

    logic [W-1:0] r_wptr, r_rptr, r_level;
    logic         r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;
    logic [W-1:0] w_wnext, w_rnext, w_lvl_nxt;

    assign o_wacc = i_wreq & ~r_full  & ~i_flush;
    assign o_racc = i_rreq & ~r_empty & ~i_flush;

    assign w_wnext   = i_flush ? '0 : r_wptr + W'(o_wacc);
    assign w_rnext   = i_flush ? '0 : r_rptr + W'(o_racc);
    assign w_lvl_nxt = w_wnext - w_rnext;

    // Flags come from next-state pointers so they match the post-edge pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wptr   <= w_wnext;
            r_rptr   <= w_rnext;
            r_level  <= w_lvl_nxt;
            r_full   <= (w_wnext[c_DEPTH_WIDTH] != w_rnext[c_DEPTH_WIDTH]) &&
                        (w_wnext[c_DEPTH_WIDTH-1:0] == w_rnext[c_DEPTH_WIDTH-1:0]);
            r_empty  <= (w_wnext == w_rnext);
            r_afull  <= (w_lvl_nxt >= W'(c_ALMOST_FULL_NUM));
            r_aempty <= (w_lvl_nxt <= W'(c_ALMOST_EMPTY_NUM));
            r_ovf    <= ~i_flush & (r_ovf | (i_wreq & r_full));
            r_udf    <= ~i_flush & (r_udf | (i_rreq & r_empty));
        end
    end

`ifdef FIFO_CTRL_PEAK_LEVEL_EN
    logic [W-1:0] r_peak;

    // Tracks the registered level, so it trails water_level by one cycle.
    always_ff @(posedge clk) begin
        if (rst || i_flush)
            r_peak <= '0;
        else if (r_level > r_peak)
            r_peak <= r_level;
    end

    assign o_peak = r_peak;
`endif

    assign o_wptr   = r_wptr[c_DEPTH_WIDTH-1:0];
    assign o_rptr   = r_rptr[c_DEPTH_WIDTH-1:0];
    assign o_full   = r_full;
    assign o_afull  = r_afull;
    assign o_empty  = r_empty;
    assign o_aempty = r_aempty;
    assign o_level  = r_level;
    assign o_ovf    = r_ovf;
    assign o_udf    = r_udf;
endmodule

module ipml_fifo_ctrl_v1_5_sync_mc #(
    parameter int c_CH_NUM           = 4,
    parameter int c_CH_SEL_WIDTH     = 2,
    parameter int c_DEPTH_WIDTH      = 9,
    parameter int c_ALMOST_FULL_NUM  = 508,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      w_en,
    input  logic [c_CH_SEL_WIDTH-1:0]                 w_ch,
    output logic                                      w_ack,
    output logic [c_CH_SEL_WIDTH+c_DEPTH_WIDTH-1:0]   waddr,
    input  logic                                      r_en,
    input  logic [c_CH_SEL_WIDTH-1:0]                 r_ch,
    output logic                                      r_ack,
    output logic [c_CH_SEL_WIDTH+c_DEPTH_WIDTH-1:0]   raddr,
    input  logic [c_CH_NUM-1:0]                       ch_flush,
    output logic [c_CH_NUM-1:0]                       wfull,
    output logic [c_CH_NUM-1:0]                       almost_full,
    output logic [c_CH_NUM-1:0]                       rempty,
    output logic [c_CH_NUM-1:0]                       almost_empty,
    output logic [c_CH_NUM*(c_DEPTH_WIDTH+1)-1:0]     water_level,
`ifdef FIFO_CTRL_PEAK_LEVEL_EN
    output logic [c_CH_NUM*(c_DEPTH_WIDTH+1)-1:0]     peak_level,
`endif
    output logic [c_CH_NUM-1:0]                       overflow,
    output logic [c_CH_NUM-1:0]                       underflow
);
    localparam int W = c_DEPTH_WIDTH + 1;

    logic [c_CH_NUM-1:0]                    w_wsel, w_rsel, w_wacc, w_racc;
    logic [c_CH_NUM-1:0][c_DEPTH_WIDTH-1:0] w_wptr, w_rptr;
    logic [c_CH_NUM-1:0][W-1:0]             w_lvl;
`ifdef FIFO_CTRL_PEAK_LEVEL_EN
    logic [c_CH_NUM-1:0][W-1:0]             w_peak;
`endif
    logic [c_DEPTH_WIDTH-1:0]               w_wptr_sel, w_rptr_sel;

    // Out-of-range channel selects decode to no channel, so they touch nothing.
    always_comb begin
        w_wsel     = '0;
        w_rsel     = '0;
        w_wptr_sel = '0;
        w_rptr_sel = '0;
        for (int k = 0; k < c_CH_NUM; k++) begin
            if (w_ch == c_CH_SEL_WIDTH'(k)) begin
                w_wsel[k]  = w_en & ~rst;
                w_wptr_sel = w_wptr[k];
            end
            if (r_ch == c_CH_SEL_WIDTH'(k)) begin
                w_rsel[k]  = r_en & ~rst;
                w_rptr_sel = w_rptr[k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < c_CH_NUM; g++) begin : g_ch
            ipml_fifo_ctrl_v1_5_sync_mc_ch #(
                .c_DEPTH_WIDTH      (c_DEPTH_WIDTH),
                .c_ALMOST_FULL_NUM  (c_ALMOST_FULL_NUM),
                .c_ALMOST_EMPTY_NUM (c_ALMOST_EMPTY_NUM)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .i_wreq   (w_wsel[g]),
                .i_rreq   (w_rsel[g]),
                .i_flush  (ch_flush[g]),
                .o_wacc   (w_wacc[g]),
                .o_racc   (w_racc[g]),
                .o_wptr   (w_wptr[g]),
                .o_rptr   (w_rptr[g]),
                .o_full   (wfull[g]),
                .o_afull  (almost_full[g]),
                .o_empty  (rempty[g]),
                .o_aempty (almost_empty[g]),
                .o_level  (w_lvl[g]),
`ifdef FIFO_CTRL_PEAK_LEVEL_EN
                .o_peak   (w_peak[g]),
`endif
                .o_ovf    (overflow[g]),
                .o_udf    (underflow[g])
            );
        end
    endgenerate

    assign w_ack       = |w_wacc;
    assign r_ack       = |w_racc;
    assign waddr       = {w_ch, w_wptr_sel};
    assign raddr       = {r_ch, w_rptr_sel};
    assign water_level = w_lvl;
`ifdef FIFO_CTRL_PEAK_LEVEL_EN
    assign peak_level  = w_peak;
`endif
endmodule

// File: tb/tb_ipml_fifo_ctrl_v1_5_sync_mc.sv
// Randomized + directed bench for ipml_fifo_ctrl_v1_5_sync_mc against a level-counting model.
// Build with FIFO_CTRL_PEAK_LEVEL_EN defined to also check peak_level.

module tb_ipml_fifo_ctrl_v1_5_sync_mc;
    localparam int CH = 4, SEL = 2, DW = 4, W = DW + 1, D = 16, AF = 14, AE = 2;

    logic              clk, rst, w_en, r_en, w_ack, r_ack;
    logic [SEL-1:0]    w_ch, r_ch;
    logic [SEL+DW-1:0] waddr, raddr;
    logic [CH-1:0]     ch_flush, wfull, almost_full, rempty, almost_empty, overflow, underflow;
    logic [CH*W-1:0]   water_level;
`ifdef FIFO_CTRL_PEAK_LEVEL_EN
    logic [CH*W-1:0]   peak_level;
`endif

    ipml_fifo_ctrl_v1_5_sync_mc #(
        .c_CH_NUM(CH), .c_CH_SEL_WIDTH(SEL), .c_DEPTH_WIDTH(DW),
        .c_ALMOST_FULL_NUM(AF), .c_ALMOST_EMPTY_NUM(AE)
    ) dut (
        .clk(clk), .rst(rst),
        .w_en(w_en), .w_ch(w_ch), .w_ack(w_ack), .waddr(waddr),
        .r_en(r_en), .r_ch(r_ch), .r_ack(r_ack), .raddr(raddr),
        .ch_flush(ch_flush), .wfull(wfull), .almost_full(almost_full),
        .rempty(rempty), .almost_empty(almost_empty), .water_level(water_level),
`ifdef FIFO_CTRL_PEAK_LEVEL_EN
        .peak_level(peak_level),
`endif
        .overflow(overflow), .underflow(underflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0, n_err = 0;
    // Model: write/read counts per channel, level is their difference.
    int wp[CH], rp[CH], lvl[CH], pk[CH];
    bit ovf[CH], udf[CH];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            wp[k] = 0; rp[k] = 0; lvl[k] = 0; pk[k] = 0; ovf[k] = 0; udf[k] = 0;
        end
    endtask

    task automatic step(input bit we, input int wc, input bit re, input int rc,
                        input logic [CH-1:0] fl, input bit rs);
        bit ew, er;
        w_en = we; w_ch = SEL'(wc); r_en = re; r_ch = SEL'(rc); ch_flush = fl; rst = rs;
        #3;
        ew = !rs && we && lvl[wc] != D && !fl[wc];
        er = !rs && re && lvl[rc] != 0 && !fl[rc];
        chk("w_ack", int'(w_ack), int'(ew));
        chk("r_ack", int'(r_ack), int'(er));
        if (!rs) begin
            chk("waddr", int'(waddr), wc * D + (wp[wc] % D));
            chk("raddr", int'(raddr), rc * D + (rp[rc] % D));
        end
        @(posedge clk);
        if (rs) model_reset();
        else begin
            for (int k = 0; k < CH; k++) begin
                pk[k] = fl[k] ? 0 : ((lvl[k] > pk[k]) ? lvl[k] : pk[k]);
                if (fl[k]) begin
                    wp[k] = 0; rp[k] = 0; lvl[k] = 0; ovf[k] = 0; udf[k] = 0;
                end else begin
                    bit ws, rsl, wa, ra;
                    ws  = we && wc == k;
                    rsl = re && rc == k;
                    wa  = ws && lvl[k] != D;
                    ra  = rsl && lvl[k] != 0;
                    if (ws && lvl[k] == D) ovf[k] = 1;
                    if (rsl && lvl[k] == 0) udf[k] = 1;
                    wp[k] += int'(wa);
                    rp[k] += int'(ra);
                    lvl[k] += int'(wa) - int'(ra);
                end
            end
        end
        #1;
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("level%0d", k), int'(water_level[k*W +: W]), lvl[k]);
            chk($sformatf("wfull%0d", k), int'(wfull[k]), int'(lvl[k] == D));
            chk($sformatf("afull%0d", k), int'(almost_full[k]), int'(lvl[k] >= AF));
            chk($sformatf("rempty%0d", k), int'(rempty[k]), int'(lvl[k] == 0));
            chk($sformatf("aempty%0d", k), int'(almost_empty[k]), int'(lvl[k] <= AE));
            chk($sformatf("ovf%0d", k), int'(overflow[k]), int'(ovf[k]));
            chk($sformatf("udf%0d", k), int'(underflow[k]), int'(udf[k]));
`ifdef FIFO_CTRL_PEAK_LEVEL_EN
            chk($sformatf("peak%0d", k), int'(peak_level[k*W +: W]), pk[k]);
`endif
        end
    endtask

    initial begin
        int wb, rb;
        model_reset();
        w_en = 0; r_en = 0; w_ch = 0; r_ch = 0; ch_flush = 0; rst = 1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 4'b0, 1);
        step(0, 0, 0, 0, 4'b0, 1);

        // Fill ch1 to full, then one write too many.
        for (int i = 0; i < 17; i++) step(1, 1, 0, 0, 4'b0, 0);
        // ch2: three words then ten simultaneous write/read pairs.
        for (int i = 0; i < 3; i++) step(1, 2, 0, 0, 4'b0, 0);
        for (int i = 0; i < 10; i++) step(1, 2, 1, 2, 4'b0, 0);
        // ch0 empty: write with same-cycle read.
        step(1, 0, 1, 0, 4'b0, 0);
        step(0, 0, 0, 0, 4'b0, 0);
        // ch3: wrap pointers past 16 and 32.
        for (int i = 0; i < 40; i++) step(1, 3, 1, 3, 4'b0, 0);
        // ch1 down to 9, then flush with a same-cycle write.
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 4'b0, 0);
        step(1, 1, 0, 0, 4'b0010, 0);
        step(0, 0, 0, 0, 4'b0, 0);
        // Reset mid-burst on ch0 / ch3.
        for (int i = 0; i < 5; i++) step(1, 0, 1, 3, 4'b0, 0);
        step(1, 0, 1, 3, 4'b0, 1);
        step(0, 0, 0, 0, 4'b0, 0);

        // Random phases alternating write-heavy and read-heavy traffic.
        for (int ph = 0; ph < 6; ph++) begin
            wb = (ph % 2 == 0) ? 3 : 1;
            rb = (ph % 2 == 0) ? 1 : 3;
            for (int i = 0; i < 400; i++) begin
                logic [CH-1:0] fl;
                fl = ($urandom_range(0, 79) == 0) ? CH'(1 << $urandom_range(0, CH-1)) : '0;
                step($urandom_range(0, 3) < wb, $urandom_range(0, CH-1),
                     $urandom_range(0, 3) < rb, $urandom_range(0, CH-1),
                     fl, $urandom_range(0, 599) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ipml_fifo_ctrl_v1_5_sync_mc.md
Name: ipml_fifo_ctrl_v1_5_sync_mc

Overview:
Single-clock, multi-channel FIFO controller. It partitions one simple-dual-port RAM into c_CH_NUM equal regions, each of depth 2^c_DEPTH_WIDTH, and each region is an independent FIFO. It provides per-channel pointers, full/empty/almost flags, water levels, flush and sticky error flags. It sits between packet sources and a shared block RAM, replacing one async controller per channel where all traffic is in one clock domain.

Parameters:
c_CH_NUM, 4, number of channels (1..16)
c_CH_SEL_WIDTH, 2, channel select width; 2^c_CH_SEL_WIDTH >= c_CH_NUM
c_DEPTH_WIDTH, 9, per-channel address width (4..16); per-channel depth D = 2^c_DEPTH_WIDTH
c_ALMOST_FULL_NUM, 508, almost_full asserted when level >= this value
c_ALMOST_EMPTY_NUM, 4, almost_empty asserted when level <= this value

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
w_en  in  1  write request
w_ch  in  c_CH_SEL_WIDTH  write channel select
w_ack  out  1  write accepted this cycle (combinational)
waddr  out  c_CH_SEL_WIDTH+c_DEPTH_WIDTH  RAM write address {w_ch, wptr[w_ch]}
r_en  in  1  read request
r_ch  in  c_CH_SEL_WIDTH  read channel select
r_ack  out  1  read accepted this cycle (combinational)
raddr  out  c_CH_SEL_WIDTH+c_DEPTH_WIDTH  RAM read address {r_ch, rptr[r_ch]}
ch_flush  in  c_CH_NUM  per-channel flush pulse
wfull  out  c_CH_NUM  per-channel full
almost_full  out  c_CH_NUM  per-channel almost full
rempty  out  c_CH_NUM  per-channel empty
almost_empty  out  c_CH_NUM  per-channel almost empty
water_level  out  c_CH_NUM*(c_DEPTH_WIDTH+1)  packed per-channel level; channel k at bits [k*(W+1) +: W+1]
overflow  out  c_CH_NUM  sticky: write attempted while full
underflow  out  c_CH_NUM  sticky: read attempted while empty

Behaviour:
- Reset (synchronous): all pointers 0. Outputs: rempty all 1, almost_empty all 1, wfull 0, almost_full 0, water_level 0, overflow 0, underflow 0.
- Pointers: each channel has a binary wptr and rptr of c_DEPTH_WIDTH+1 bits. The extra MSB is the wrap bit. Pointers wrap modulo 2^(c_DEPTH_WIDTH+1).
- Write accept: w_ack = w_en & ~wfull[w_ch] & ~ch_flush[w_ch]. When w_ack is high, wptr[w_ch] increments at the clock edge. The RAM writes at waddr on the same edge.
- Read accept: r_ack = r_en & ~rempty[r_ch] & ~ch_flush[r_ch]. When r_ack is high, rptr[r_ch] increments at the edge. RAM output latency is owned by the RAM wrapper.
- w_ch or r_ch >= c_CH_NUM: the request is ignored, ack is 0, and no flags change.
- Flags are registered from next-state pointers, so every flag reflects the post-edge state with no extra cycle of latency.
  - full = wrap bits differ and low bits are equal.
  - empty = pointers equal.
  - level = wptr - rptr (mod 2^(c_DEPTH_WIDTH+1)), range 0..D.
- Same-channel simultaneous write and read, both accepted: level is unchanged and flags hold.
- Write to a full channel with a same-cycle read: the write is rejected (no bypass); the read proceeds, so the channel is not full next cycle.
- Read from an empty channel with a same-cycle write: the read is rejected; the channel is not empty next cycle.
- Writes and reads to different channels are fully independent.
- Flush: ch_flush[k] sets wptr[k] = rptr[k] = 0 and clears overflow[k] and underflow[k]. The next cycle shows empty and level 0. Flush overrides a same-cycle write or read on channel k (that ack is 0, no sticky flag is set). Other channels are unaffected.
- Sticky flags: w_en to a full channel sets overflow[w_ch]; r_en to an empty channel sets underflow[r_ch]. They clear only on rst or flush.
- Reset mid-traffic: rst overrides all requests in that cycle; acks are 0 while rst is high.

Optional Feature:
Macro FIFO_CTRL_PEAK_LEVEL_EN.
- Defined: adds output peak_level [c_CH_NUM*(c_DEPTH_WIDTH+1)], the per-channel maximum registered water_level since reset or flush of that channel. It updates the cycle after water_level exceeds it and clears to 0 on rst or ch_flush[k].
- Undefined: the port is absent and no peak registers are built.

Test Plan:
Bench parameters for all scenarios: c_CH_NUM=4, c_DEPTH_WIDTH=4, AF=14, AE=2.
- Reset, then 16 writes to ch1 -> wfull[1]=1 after the 16th edge, water_level[1]=16, almost_full[1] rises after the 14th write. A 17th write gives w_ack=0 and overflow[1]=1; other channels stay rempty=1.
- Fill ch2 with 3 words, then issue simultaneous w_en/r_en on ch2 for 10 cycles -> level stays 3 and rempty[2]=0 throughout. raddr low bits step 0..9 and waddr low bits step 3..12.
- ch0 empty, same-cycle w_en and r_en on ch0 -> w_ack=1, r_ack=0, underflow[0]=1. The next cycle shows level=1 and rempty[0]=0.
- 40 write/read pairs on ch3 -> pointers wrap past 16 and 32. Flags stay correct at each wrap, and waddr/raddr carry channel bits 2'b11.
- ch1 at level 9 with overflow set, then pulse ch_flush[1] together with w_en on ch1 -> w_ack=0. The next cycle shows level 0, rempty[1]=1 and overflow[1]=0; ch2 contents are unchanged.
- rst asserted mid-burst on ch0 and ch3 -> the next cycle shows all levels 0, all rempty=1 and all sticky flags 0. With FIFO_CTRL_PEAK_LEVEL_EN, peak_level is 0 for every channel.
